// File: rtl/mips_pkg.sv
`default_nettype none
// ==========================================================================
// mips_pkg: shared widths and requester encoding for the writeback scheduler
// Revision: 1.0
// ==========================================================================
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return NUM_REGS'(1) << r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_scoreboard.sv
`default_nettype none
// ==========================================================================
// mips_scoreboard: 1-bit-per-register pending-write tracker and hazard stall
// Revision: 1.0
// ==========================================================================
module mips_scoreboard
  import mips_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set,
  input  logic [REG_ADDR_W-1:0] set_reg,
  input  logic                  clr,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  input  logic [REG_ADDR_W-1:0] rd1,
  input  logic [REG_ADDR_W-1:0] rd2,
  output logic                  stall
);

  localparam logic [NUM_REGS-1:0] c_R0_MASK = NUM_REGS'(1);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;

  assign w_set_vec = set ? reg_onehot(set_reg) : '0;
  assign w_clr_vec = clr ? reg_onehot(clr_reg) : '0;

  // Set is applied after clear so a new producer keeps ownership; r0 is never busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr_vec) | w_set_vec) & ~c_R0_MASK;
    end
  end

  assign stall = r_busy[rd1] | r_busy[rd2];

endmodule
`default_nettype wire

// File: rtl/mips_regfile_write_scheduler.sv
`default_nettype none
// ==========================================================================
// mips_regfile_write_scheduler: arbitrates ALU/load writebacks onto one RF write port
// Revision: 1.0
// ==========================================================================
module mips_regfile_write_scheduler
  import mips_pkg::*;
#(
  parameter int unsigned MEM_PRIORITY = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_req_valid,
  input  logic [REG_ADDR_W-1:0] alu_req_reg,
  input  logic [DATA_W-1:0]     alu_req_data,
  output logic                  alu_req_ready,
  input  logic                  mem_req_valid,
  input  logic [REG_ADDR_W-1:0] mem_req_reg,
  input  logic [DATA_W-1:0]     mem_req_data,
  output logic                  mem_req_ready,
  input  logic                  reserve_valid,
  input  logic [REG_ADDR_W-1:0] reserve_reg,
  input  logic [REG_ADDR_W-1:0] read_reg_1,
  input  logic [REG_ADDR_W-1:0] read_reg_2,
  output logic                  stall,
  output logic                  signal_reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data
);

  req_e                  r_last_grant;
  logic                  r_wr_en;
  logic [REG_ADDR_W-1:0] r_wr_reg;
  logic [DATA_W-1:0]     r_wr_data;

  logic                  w_alu_wins_tie;
  logic                  w_alu_ready;
  logic                  w_mem_ready;
  logic                  w_accept;
  logic [REG_ADDR_W-1:0] w_sel_reg;
  logic [DATA_W-1:0]     w_sel_data;

  // On a tie, ALU wins only in round-robin mode and only if MEM was granted last.
  always_comb begin
    w_alu_wins_tie = (MEM_PRIORITY == 0) && (r_last_grant == REQ_MEM);
    w_alu_ready    = 1'b0;
    w_mem_ready    = 1'b0;
    if (!reset) begin
      if (alu_req_valid && mem_req_valid) begin
        w_alu_ready = w_alu_wins_tie;
        w_mem_ready = !w_alu_wins_tie;
      end else begin
        w_alu_ready = alu_req_valid;
        w_mem_ready = mem_req_valid;
      end
    end
  end

  assign w_accept   = w_alu_ready | w_mem_ready;
  assign w_sel_reg  = w_mem_ready ? mem_req_reg  : alu_req_reg;
  assign w_sel_data = w_mem_ready ? mem_req_data : alu_req_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_en      <= 1'b0;
      r_wr_reg     <= '0;
      r_wr_data    <= '0;
      r_last_grant <= REQ_MEM;
    end else if (w_accept) begin
      r_wr_en      <= (w_sel_reg != '0);
      r_wr_reg     <= w_sel_reg;
      r_wr_data    <= w_sel_data;
      r_last_grant <= w_mem_ready ? REQ_MEM : REQ_ALU;
    end else begin
      r_wr_en      <= 1'b0;
    end
  end

  mips_scoreboard u_scoreboard (
    .clock   (clock),
    .reset   (reset),
    .set     (reserve_valid),
    .set_reg (reserve_reg),
    .clr     (r_wr_en),
    .clr_reg (r_wr_reg),
    .rd1     (read_reg_1),
    .rd2     (read_reg_2),
    .stall   (stall)
  );

  assign alu_req_ready    = w_alu_ready;
  assign mem_req_ready    = w_mem_ready;
  assign signal_reg_write = r_wr_en;
  assign write_reg        = r_wr_reg;
  assign write_data       = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_write_scheduler.sv
`default_nettype none
// ==========================================================================
// tb_mips_regfile_write_scheduler: directed scenarios plus randomized model comparison
// Revision: 1.0
// ==========================================================================
module tb_mips_regfile_write_scheduler;

  logic        clock;
  logic        reset;
  logic        alu_req_valid, mem_req_valid;
  logic [4:0]  alu_req_reg, mem_req_reg;
  logic [31:0] alu_req_data, mem_req_data;
  logic        alu_req_ready, mem_req_ready;
  logic        reserve_valid;
  logic [4:0]  reserve_reg, read_reg_1, read_reg_2;
  logic        stall, signal_reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  logic        p_alu_req_valid, p_mem_req_valid;
  logic [4:0]  p_alu_req_reg, p_mem_req_reg;
  logic [31:0] p_alu_req_data, p_mem_req_data;
  logic        p_alu_req_ready, p_mem_req_ready;
  logic        p_stall, p_signal_reg_write;
  logic [4:0]  p_write_reg;
  logic [31:0] p_write_data;

  int checks;
  int errors;

  mips_regfile_write_scheduler #(.MEM_PRIORITY(0)) dut (
    .clock(clock), .reset(reset),
    .alu_req_valid(alu_req_valid), .alu_req_reg(alu_req_reg), .alu_req_data(alu_req_data),
    .alu_req_ready(alu_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_reg(mem_req_reg), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready),
    .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .stall(stall),
    .signal_reg_write(signal_reg_write), .write_reg(write_reg), .write_data(write_data)
  );

  mips_regfile_write_scheduler #(.MEM_PRIORITY(1)) dut_mp (
    .clock(clock), .reset(reset),
    .alu_req_valid(p_alu_req_valid), .alu_req_reg(p_alu_req_reg), .alu_req_data(p_alu_req_data),
    .alu_req_ready(p_alu_req_ready),
    .mem_req_valid(p_mem_req_valid), .mem_req_reg(p_mem_req_reg), .mem_req_data(p_mem_req_data),
    .mem_req_ready(p_mem_req_ready),
    .reserve_valid(reserve_valid), .reserve_reg(reserve_reg),
    .read_reg_1(read_reg_1), .read_reg_2(read_reg_2), .stall(p_stall),
    .signal_reg_write(p_signal_reg_write), .write_reg(p_write_reg), .write_data(p_write_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alu_req_valid = 0; alu_req_reg = 0; alu_req_data = 0;
    mem_req_valid = 0; mem_req_reg = 0; mem_req_data = 0;
    p_alu_req_valid = 0; p_alu_req_reg = 0; p_alu_req_data = 0;
    p_mem_req_valid = 0; p_mem_req_reg = 0; p_mem_req_data = 0;
    reserve_valid = 0; reserve_reg = 0; read_reg_1 = 0; read_reg_2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    next_cycle();
    next_cycle();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    alu_req_valid = 1; alu_req_reg = 5'd9; alu_req_data = 32'h99;
    mem_req_valid = 1; mem_req_reg = 5'd10; mem_req_data = 32'haa;
    p_mem_req_valid = 1; p_mem_req_reg = 5'd10;
    @(negedge clock);
    checks++;
    if (alu_req_ready !== 1'b0 || mem_req_ready !== 1'b0 || p_mem_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got alu=%b mem=%b pmem=%b expected 0 0 0",
               alu_req_ready, mem_req_ready, p_mem_req_ready);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (signal_reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b reg=%0d data=%h expected 0 0 0",
               signal_reg_write, write_reg, write_data);
    end
    for (int r = 0; r < 32; r++) begin
      read_reg_1 = 5'(r); read_reg_2 = 5'(r);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL reset_stall: reg %0d got %b expected 0", r, stall);
      end
    end
    next_cycle();
    idle_inputs();
    reset = 0;
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    alu_req_valid = 1; alu_req_reg = 5'd3; alu_req_data = 32'h11;
    mem_req_valid = 1; mem_req_reg = 5'd4; mem_req_data = 32'h22;
    @(negedge clock);
    checks++;
    if (alu_req_ready !== 1'b1 || mem_req_ready !== 1'b0 || signal_reg_write !== 1'b0) begin
      errors++;
      $display("FAIL tie_first: got alu=%b mem=%b en=%b expected 1 0 0",
               alu_req_ready, mem_req_ready, signal_reg_write);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (alu_req_ready !== 1'b0 || mem_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL tie_second: got alu=%b mem=%b expected 0 1", alu_req_ready, mem_req_ready);
    end
    checks++;
    if (signal_reg_write !== 1'b1 || write_reg !== 5'd3 || write_data !== 32'h11) begin
      errors++;
      $display("FAIL tie_write_alu: got en=%b reg=%0d data=%h expected 1 3 11",
               signal_reg_write, write_reg, write_data);
    end
    next_cycle();
    alu_req_valid = 0; mem_req_valid = 0;
    @(negedge clock);
    checks++;
    if (signal_reg_write !== 1'b1 || write_reg !== 5'd4 || write_data !== 32'h22) begin
      errors++;
      $display("FAIL tie_write_mem: got en=%b reg=%0d data=%h expected 1 4 22",
               signal_reg_write, write_reg, write_data);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (signal_reg_write !== 1'b0 || write_reg !== 5'd4 || write_data !== 32'h22) begin
      errors++;
      $display("FAIL idle_hold: got en=%b reg=%0d data=%h expected 0 4 22",
               signal_reg_write, write_reg, write_data);
    end
    next_cycle();
  endtask

  task automatic test_mem_priority();
    do_reset();
    p_alu_req_valid = 1; p_alu_req_reg = 5'd6; p_alu_req_data = 32'h66;
    p_mem_req_valid = 1; p_mem_req_reg = 5'd8; p_mem_req_data = 32'h88;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (p_mem_req_ready !== 1'b1 || p_alu_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL mem_priority cyc %0d: got alu=%b mem=%b expected 0 1",
                 c, p_alu_req_ready, p_mem_req_ready);
      end
      if (c > 0) begin
        checks++;
        if (p_signal_reg_write !== 1'b1 || p_write_reg !== 5'd8 || p_write_data !== 32'h88) begin
          errors++;
          $display("FAIL mem_priority_write cyc %0d: got en=%b reg=%0d data=%h expected 1 8 88",
                   c, p_signal_reg_write, p_write_reg, p_write_data);
        end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      alu_req_valid = 1; alu_req_reg = 5'(c + 11); alu_req_data = 32'hB000 + 32'(c);
      @(negedge clock);
      checks++;
      if (alu_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready cyc %0d: got %b expected 1", c, alu_req_ready);
      end
      if (c > 0) begin
        checks++;
        if (signal_reg_write !== 1'b1 || write_reg !== 5'(c + 10) || write_data !== 32'hB000 + 32'(c - 1)) begin
          errors++;
          $display("FAIL b2b_write cyc %0d: got en=%b reg=%0d data=%h expected 1 %0d %h",
                   c, signal_reg_write, write_reg, write_data, c + 10, 32'hB000 + 32'(c - 1));
        end
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_stall();
    do_reset();
    reserve_valid = 1; reserve_reg = 5'd7; read_reg_1 = 5'd7; read_reg_2 = 5'd0;
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_same_cycle_reserve: got %b expected 0", stall);
    end
    next_cycle();
    reserve_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_pending cyc %0d: got %b expected 1", c, stall);
      end
      next_cycle();
    end
    alu_req_valid = 1; alu_req_reg = 5'd7; alu_req_data = 32'h77;
    @(negedge clock);
    checks++;
    if (stall !== 1'b1 || alu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_grant: got stall=%b ready=%b expected 1 1", stall, alu_req_ready);
    end
    next_cycle();
    alu_req_valid = 0;
    @(negedge clock);
    checks++;
    if (stall !== 1'b1 || signal_reg_write !== 1'b1 || write_reg !== 5'd7) begin
      errors++;
      $display("FAIL stall_write_cycle: got stall=%b en=%b reg=%0d expected 1 1 7",
               stall, signal_reg_write, write_reg);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_released: got %b expected 0", stall);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_set_clear_same_cycle();
    do_reset();
    reserve_valid = 1; reserve_reg = 5'd5;
    next_cycle();
    reserve_valid = 0;
    alu_req_valid = 1; alu_req_reg = 5'd5; alu_req_data = 32'h55;
    read_reg_1 = 5'd0; read_reg_2 = 5'd5;
    next_cycle();
    alu_req_valid = 0;
    reserve_valid = 1; reserve_reg = 5'd5;
    @(negedge clock);
    checks++;
    if (signal_reg_write !== 1'b1 || write_reg !== 5'd5 || stall !== 1'b1) begin
      errors++;
      $display("FAIL setclr_write: got en=%b reg=%0d stall=%b expected 1 5 1",
               signal_reg_write, write_reg, stall);
    end
    next_cycle();
    reserve_valid = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (stall !== 1'b1) begin
        errors++;
        $display("FAIL setclr_busy_kept cyc %0d: got %b expected 1", c, stall);
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reg0();
    do_reset();
    alu_req_valid = 1; alu_req_reg = 5'd0; alu_req_data = 32'hFFFF_FFFF;
    reserve_valid = 1; reserve_reg = 5'd0; read_reg_1 = 5'd0; read_reg_2 = 5'd0;
    @(negedge clock);
    checks++;
    if (alu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reg0_ready: got %b expected 1", alu_req_ready);
    end
    next_cycle();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (signal_reg_write !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reg0_no_write: got en=%b stall=%b expected 0 0", signal_reg_write, stall);
    end
    next_cycle();
  endtask

  task automatic test_reset_cancel();
    do_reset();
    reserve_valid = 1; reserve_reg = 5'd9;
    next_cycle();
    reserve_reg = 5'd12;
    alu_req_valid = 1; alu_req_reg = 5'd20; alu_req_data = 32'h2020;
    next_cycle();
    reserve_valid = 0;
    alu_req_reg = 5'd9; alu_req_data = 32'h99;
    reset = 1;
    @(negedge clock);
    checks++;
    if (alu_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstcancel_ready: got %b expected 0", alu_req_ready);
    end
    next_cycle();
    reset = 0;
    alu_req_valid = 0;
    @(negedge clock);
    checks++;
    if (signal_reg_write !== 1'b0 || write_reg !== 5'd0 || write_data !== 32'd0) begin
      errors++;
      $display("FAIL rstcancel_outputs: got en=%b reg=%0d data=%h expected 0 0 0",
               signal_reg_write, write_reg, write_data);
    end
    for (int r = 0; r < 32; r++) begin
      read_reg_1 = 5'(r); read_reg_2 = 5'(31 - r);
      #1;
      checks++;
      if (stall !== 1'b0) begin
        errors++;
        $display("FAIL rstcancel_busy: reg %0d got %b expected 0", r, stall);
      end
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [31:0] m_busy;
    logic        m_last_mem;
    logic        m_en;
    logic [4:0]  m_reg;
    logic [31:0] m_data;
    logic        ea, em, est;
    do_reset();
    m_busy = '0; m_last_mem = 1'b1; m_en = 1'b0; m_reg = '0; m_data = '0;
    for (int c = 0; c < 400; c++) begin
      if (!alu_req_valid) begin
        alu_req_valid = 1'($urandom_range(1, 0));
        alu_req_reg   = 5'($urandom_range(31, 0));
        alu_req_data  = $urandom;
      end
      if (!mem_req_valid) begin
        mem_req_valid = 1'($urandom_range(1, 0));
        mem_req_reg   = 5'($urandom_range(31, 0));
        mem_req_data  = $urandom;
      end
      reserve_valid = ($urandom_range(3, 0) == 0);
      reserve_reg   = 5'($urandom_range(31, 0));
      read_reg_1    = 5'($urandom_range(31, 0));
      read_reg_2    = 5'($urandom_range(31, 0));
      if (alu_req_valid && mem_req_valid) begin
        ea = m_last_mem;
        em = !m_last_mem;
      end else begin
        ea = alu_req_valid;
        em = mem_req_valid;
      end
      est = m_busy[read_reg_1] | m_busy[read_reg_2];
      @(negedge clock);
      checks++;
      if (alu_req_ready !== ea || mem_req_ready !== em) begin
        errors++;
        $display("FAIL rand_ready cyc %0d: got alu=%b mem=%b expected %b %b",
                 c, alu_req_ready, mem_req_ready, ea, em);
      end
      checks++;
      if (stall !== est) begin
        errors++;
        $display("FAIL rand_stall cyc %0d: got %b expected %b", c, stall, est);
      end
      checks++;
      if (signal_reg_write !== m_en) begin
        errors++;
        $display("FAIL rand_wen cyc %0d: got %b expected %b", c, signal_reg_write, m_en);
      end else if (m_en && (write_reg !== m_reg || write_data !== m_data)) begin
        errors++;
        $display("FAIL rand_wdata cyc %0d: got reg=%0d data=%h expected %0d %h",
                 c, write_reg, write_data, m_reg, m_data);
      end
      next_cycle();
      if (m_en) m_busy[m_reg] = 1'b0;
      if (reserve_valid && reserve_reg != 5'd0) m_busy[reserve_reg] = 1'b1;
      if (ea || em) begin
        m_reg      = em ? mem_req_reg : alu_req_reg;
        m_data     = em ? mem_req_data : alu_req_data;
        m_en       = (m_reg != 5'd0);
        m_last_mem = em;
      end else begin
        m_en = 1'b0;
      end
      if (ea) alu_req_valid = 1'b0;
      if (em) mem_req_valid = 1'b0;
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_tie_round_robin();
    test_mem_priority();
    test_back_to_back();
    test_stall();
    test_set_clear_same_cycle();
    test_reg0();
    test_reset_cancel();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
